act_buf_loader: RTL

ACT_BUF_LOADER -- requirements
Module: act_buf_loader

---
 rtl/act_buf_loader.sv | 123 ++++++++++++
 1 files changed

// File: rtl/act_buf_loader.sv
// Activation buffer loader: packs DMA beats into buffer lines and writes
// them to consecutive line addresses, one write per completed line.
module act_buf_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int ACT_WIDTH  = 1024,
  parameter int IN_WIDTH   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_lines,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  output logic                  buf_wr_en,
  output logic [ADDR_WIDTH-1:0] buf_wr_addr,
  output logic [ACT_WIDTH-1:0]  buf_wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam int BEATS = ACT_WIDTH / IN_WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [ADDR_WIDTH:0]   line_q, line_d;
  logic [ADDR_WIDTH:0]   num_q, num_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [ACT_WIDTH-1:0]  act_q, act_d;
  logic [ACT_WIDTH-1:0]  data_d;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    line_d  = line_q;
    num_d   = num_q;
    base_d  = base_q;
    act_d   = act_q;
    addr_d  = buf_wr_addr;
    data_d  = buf_wr_data;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          num_d   = num_lines;
          beat_d  = '0;
          line_d  = '0;
          state_d = (num_lines == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (in_valid && in_ready) begin
          act_d[int'(beat_q)*IN_WIDTH +: IN_WIDTH] = in_data;
          if (beat_q == BW'(BEATS-1)) begin
            beat_d  = '0;
            state_d = WRITE;
            addr_d  = base_q + line_q[ADDR_WIDTH-1:0];
            data_d  = act_d;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      WRITE: begin
        // line count is one bit wider so a full 2^ADDR_WIDTH load terminates
        if (line_q + 1'b1 == num_q) begin
          state_d = DONE;
        end else begin
          line_d  = line_q + 1'b1;
          beat_d  = '0;
          state_d = FILL;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      line_q      <= '0;
      num_q       <= '0;
      base_q      <= '0;
      act_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      in_ready    <= 1'b0;
      buf_wr_en   <= 1'b0;
      buf_wr_addr <= '0;
      buf_wr_data <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      line_q      <= line_d;
      num_q       <= num_d;
      base_q      <= base_d;
      act_q       <= act_d;
      busy        <= (state_d != IDLE);
      done        <= (state_d == DONE);
      in_ready    <= (state_d == FILL);
      buf_wr_en   <= (state_d == WRITE);
      buf_wr_addr <= addr_d;
      buf_wr_data <= data_d;
    end
  end

endmodule
